// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam int          INSTR_W   = 32;
    localparam int          PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus: imem request/ack, decode hand-off and redirect inputs.
interface pc_fetch_sequencer_if
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic               imem_req;
    logic [WIDTH-1:0]   imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [WIDTH-1:0]   if_pc;
    logic               id_stall;
    logic               br_taken;
    logic [WIDTH-1:0]   br_target;
    logic               trap_req;
    logic [WIDTH-1:0]   trap_vec;
    logic               misalign;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, misalign,
        input  imem_ack, imem_rdata, id_stall, br_taken, br_target, trap_req, trap_vec
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, misalign,
        output imem_ack, imem_rdata, id_stall, br_taken, br_target, trap_req, trap_vec
    );
endinterface

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// Next-PC priority mux: trap beats branch beats sequential; flags unaligned redirect targets.
module pc_fetch_sequencer_next_pc_sel
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             en,
    input  logic             advance,
    input  logic             trap_req,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect,
    output logic             misalign
);
    logic [WIDTH-1:0] sel_target;

    always_comb begin
        sel_target = trap_req ? trap_vec : br_target;
        redirect   = en & (trap_req | br_taken);
        misalign   = redirect & (|sel_target[1:0]);
        if (redirect) begin
            next_pc = {sel_target[WIDTH-1:2], 2'b00};
        end else if (advance) begin
            next_pc = pc + WIDTH'(PC_INC);
        end else begin
            next_pc = pc;
        end
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch FSM for the single-issue core.
// Optional PC_SEQ_PERF_CNT_EN adds perf_fetch / perf_stall counters.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch,
    output logic [31:0]          perf_stall
`endif
);
    state_e             state_reg;
    logic [WIDTH-1:0]   pc_reg;
    logic [WIDTH-1:0]   addr_reg;
    logic               req_reg;
    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [WIDTH-1:0]   if_pc_reg;
    logic               misalign_reg;

    logic [WIDTH-1:0]   pc_next;
    logic               redirect;
    logic               misalign_next;
    logic               fetch_ack;

    assign fetch_ack = (state_reg == FETCH) && bus.imem_ack;

    pc_fetch_sequencer_next_pc_sel #(.WIDTH(WIDTH)) u_next_pc_sel (
        .pc        (pc_reg),
        .en        (state_reg != BOOT),
        .advance   (fetch_ack),
        .trap_req  (bus.trap_req),
        .trap_vec  (bus.trap_vec),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .next_pc   (pc_next),
        .redirect  (redirect),
        .misalign  (misalign_next)
    );

    // addr_reg tracks pc except while a dead request is still outstanding,
    // where it must hold the old address until imem acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            addr_reg     <= RESET_PC;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            if_pc_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
            case (state_reg)
                BOOT: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                    addr_reg  <= pc_next;
                end
                FETCH: begin
                    if (redirect && !bus.imem_ack) begin
                        state_reg <= SQUASH;
                    end else if (bus.imem_ack && !redirect) begin
                        instr_reg <= bus.imem_rdata;
                        if_pc_reg <= pc_reg;
                        valid_reg <= 1'b1;
                        req_reg   <= 1'b0;
                        addr_reg  <= pc_next;
                        state_reg <= HOLD;
                    end else begin
                        addr_reg  <= pc_next;
                    end
                end
                SQUASH: begin
                    if (bus.imem_ack) begin
                        addr_reg  <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect || !bus.id_stall) begin
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        addr_reg  <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= BOOT;
            endcase
        end
    end

    assign bus.imem_req  = req_reg;
    assign bus.imem_addr = addr_reg;
    assign bus.if_valid  = valid_reg;
    assign bus.if_instr  = instr_reg;
    assign bus.if_pc     = if_pc_reg;
    assign bus.misalign  = misalign_reg;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (fetch_ack && !redirect) begin
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            end
            if ((state_reg == HOLD) && bus.id_stall) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_reg;
    assign perf_stall = perf_stall_reg;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: delivered fetches are queued, popped as if_valid rises.
module tb_pc_fetch_sequencer;
    import pc_fetch_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [31:0] exp_pc;
    logic valid_d = 1'b0;

    pc_fetch_sequencer_if #(.WIDTH(32)) bus();

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PC_SEQ_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising if_valid must match the oldest delivered fetch.
    always @(negedge clk) begin
        if (!rst && bus.if_valid && !valid_d) begin
            check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn if_pc=%h if_instr=%h exp_pc=%h", bus.if_pc, bus.if_instr, e.pc);
                check("sb_pc", bus.if_pc, e.pc);
                check("sb_instr", bus.if_instr, e.instr);
            end
        end
        valid_d <= bus.if_valid;
    end

    task automatic do_fetch(input int waits, input bit hold);
        check("req", bus.imem_req, 1);
        check("addr", bus.imem_addr, exp_pc);
        for (int w = 0; w < waits; w++) begin
            tick();
            check("addr_wait", bus.imem_addr, exp_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mk_instr(exp_pc);
        sb_q.push_back('{pc: exp_pc, instr: mk_instr(exp_pc)});
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check("if_valid", bus.if_valid, 1);
        check("req_in_hold", bus.imem_req, 0);
        exp_pc = exp_pc + 32'd4;
        if (!hold) tick();
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.id_stall   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus.trap_req   = 1'b0;
        bus.trap_vec   = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_valid", bus.if_valid, 0);
        check("rst_instr", bus.if_instr, 0);
        check("rst_pc", bus.if_pc, 0);
        check("rst_misalign", bus.misalign, 0);
        rst = 1'b0;
        tick();
        exp_pc = RST_PC;

        // Back-to-back sequential fetches
        for (int i = 0; i < 3; i++) do_fetch(0, 1'b0);

        // Decode stall in HOLD, with a stray ack that must be ignored
        do_fetch(0, 1'b1);
        bus.id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = NOP_INSTR;
            end
            tick();
            bus.imem_ack = 1'b0;
            check("stall_valid", bus.if_valid, 1);
            check("stall_pc", bus.if_pc, 32'h0000_010C);
            check("stall_instr", bus.if_instr, mk_instr(32'h0000_010C));
            check("stall_req", bus.imem_req, 0);
        end
        bus.id_stall = 1'b0;
        tick();

        // Branch while the fetch waits 3 cycles for ack
        check("pre_br_addr", bus.imem_addr, exp_pc);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0200;
        tick();
        bus.br_taken  = 1'b0;
        check("sq_req", bus.imem_req, 1);
        check("sq_addr", bus.imem_addr, 32'h0000_0110);
        check("sq_misalign", bus.misalign, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sq_addr_hold", bus.imem_addr, 32'h0000_0110);
            check("sq_valid", bus.if_valid, 0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = NOP_INSTR;
        tick();
        bus.imem_ack   = 1'b0;
        check("sq_drop_valid", bus.if_valid, 0);
        exp_pc = 32'h0000_0200;
        do_fetch(0, 1'b0);

        // Branch in the same cycle as ack: data dropped
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = NOP_INSTR;
        bus.br_taken   = 1'b1;
        bus.br_target  = 32'h0000_0240;
        tick();
        bus.imem_ack = 1'b0;
        bus.br_taken = 1'b0;
        check("brack_valid", bus.if_valid, 0);
        check("brack_addr", bus.imem_addr, 32'h0000_0240);
        exp_pc = 32'h0000_0240;

        // Trap beats branch in HOLD
        do_fetch(0, 1'b1);
        bus.trap_req  = 1'b1;
        bus.trap_vec  = 32'h0000_0080;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0300;
        tick();
        bus.trap_req = 1'b0;
        bus.br_taken = 1'b0;
        check("trap_valid", bus.if_valid, 0);
        check("trap_addr", bus.imem_addr, 32'h0000_0080);
        exp_pc = 32'h0000_0080;
        do_fetch(0, 1'b0);

        // Misaligned branch target
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = NOP_INSTR;
        bus.br_taken   = 1'b1;
        bus.br_target  = 32'h0000_0203;
        tick();
        bus.imem_ack = 1'b0;
        bus.br_taken = 1'b0;
        check("mis_pulse", bus.misalign, 1);
        check("mis_addr", bus.imem_addr, 32'h0000_0200);
        tick();
        check("mis_clear", bus.misalign, 0);
        exp_pc = 32'h0000_0200;
        do_fetch(0, 1'b0);

        // PC wrap at the top of the address space
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = NOP_INSTR;
        bus.br_taken   = 1'b1;
        bus.br_target  = 32'hFFFF_FFFC;
        tick();
        bus.imem_ack = 1'b0;
        bus.br_taken = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        do_fetch(0, 1'b0);
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);
        do_fetch(0, 1'b0);

        // Reset while squashing; late ack during BOOT ignored
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0400;
        tick();
        bus.br_taken  = 1'b0;
        check("rsq_addr", bus.imem_addr, 32'h0000_0004);
        rst = 1'b1;
        tick();
        check("rsq_req", bus.imem_req, 0);
        check("rsq_valid", bus.if_valid, 0);
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = NOP_INSTR;
        tick();
        bus.imem_ack = 1'b0;
        check("boot_ack_valid", bus.if_valid, 0);
        check("boot_req", bus.imem_req, 1);
        exp_pc = RST_PC;
        do_fetch(0, 1'b0);

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
